// File: rtl/rv32_fetch_unit.sv
// -----------------------------------------------------------------------------
// rv32_fetch_unit
// Instruction-fetch producer for the 5-stage RV32 core. Owns the fetch PC,
// issues word reads to instruction memory, buffers returned words together
// with their PCs and presents the head entry to the IF/ID register. Wrong-path
// responses still in flight at a redirect are counted and discarded on return.
//
// Parameters
//   RESET_PC    fetch address after reset (bits [1:0] ignored, must be 0)
//   FIFO_DEPTH  buffered instructions plus in-flight requests (power of 2, >=2)
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   stall              IF/ID holds this cycle; head entry is not consumed
//   redirect_valid/pc  restart fetch at redirect_pc, flush buffered work
//   imem_req_*         word read request (valid/ready/addr)
//   imem_rsp_*         in-order read response (valid/data)
//   code_out, pc_out   head instruction and its PC (NOP / 0 when empty)
//   fetch_valid        code_out/pc_out hold a real fetched instruction
//   fetch_misaligned   (RV32_FETCH_ALIGN_CHECK_EN only) sticky misaligned
//                      redirect flag; blocks fetch until an aligned redirect
//
// Configuration macro: RV32_FETCH_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
module rv32_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] code_out,
   output logic [31:0] pc_out,
   output logic        fetch_valid
`ifdef RV32_FETCH_ALIGN_CHECK_EN
   ,
   output logic        fetch_misaligned
`endif
);

   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SW  = CW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] code;
   } fetch_entry_t;

   // Architectural state
   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]  occ_q, occ_d;
   logic [CW-1:0]  outst_q, outst_d;
   logic [CW-1:0]  drop_q, drop_d;

   // PC tag FIFO: addresses of requests whose data is still wanted
   logic [31:0]    tag_mem_q [FIFO_DEPTH];
   logic [PW-1:0]  tag_wr_q, tag_wr_d;
   logic [PW-1:0]  tag_rd_q, tag_rd_d;

   // Instruction FIFO feeding IF/ID
   fetch_entry_t   ins_mem_q [FIFO_DEPTH];
   logic [PW-1:0]  ins_wr_q, ins_wr_d;
   logic [PW-1:0]  ins_rd_q, ins_rd_d;

   logic           req_block_c;
   logic           credit_ok_c;
   logic           req_fire_c;
   logic           rsp_ok_c;
   logic           rsp_keep_c;
   logic           ins_push_c;
   logic           pop_c;
   fetch_entry_t   head_c;

`ifdef RV32_FETCH_ALIGN_CHECK_EN
   logic           misal_q, misal_d;
   assign req_block_c      = misal_q;
   assign fetch_misaligned = misal_q;
`else
   assign req_block_c      = 1'b0;
`endif

   // Request credit: buffered plus in-flight (including doomed ones) below depth
   assign credit_ok_c    = (SW'(occ_q) + SW'(outst_q)) < SW'(FIFO_DEPTH);
   assign imem_req_valid = ~rst & ~redirect_valid & ~req_block_c & credit_ok_c;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire_c     = imem_req_valid & imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored
   assign rsp_ok_c   = imem_rsp_valid & (outst_q != '0);
   assign rsp_keep_c = rsp_ok_c & (drop_q == '0);
   assign ins_push_c = rsp_keep_c & ~redirect_valid;

   // Head of the instruction FIFO drives IF/ID directly
   assign head_c      = ins_mem_q[ins_rd_q];
   assign fetch_valid = ~rst & (occ_q != '0);
   assign pop_c       = fetch_valid & ~stall & ~redirect_valid;
   assign code_out    = fetch_valid ? head_c.code : NOP;
   assign pc_out      = fetch_valid ? head_c.pc : 32'h0000_0000;

   // Next-state logic; redirect overrides every other update
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      occ_d      = occ_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      tag_wr_d   = tag_wr_q;
      tag_rd_d   = tag_rd_q;
      ins_wr_d   = ins_wr_q;
      ins_rd_d   = ins_rd_q;
`ifdef RV32_FETCH_ALIGN_CHECK_EN
      misal_d    = misal_q;
`endif

      if (req_fire_c) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         tag_wr_d   = tag_wr_q + PW'(1);
      end

      outst_d = outst_q + CW'(req_fire_c) - CW'(rsp_ok_c);

      if (rsp_ok_c && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end

      if (rsp_keep_c) begin
         tag_rd_d = tag_rd_q + PW'(1);
         ins_wr_d = ins_wr_q + PW'(1);
      end

      if (pop_c) begin
         ins_rd_d = ins_rd_q + PW'(1);
      end

      occ_d = occ_q + CW'(ins_push_c) - CW'(pop_c);

      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path
         occ_d      = '0;
         tag_wr_d   = '0;
         tag_rd_d   = '0;
         ins_wr_d   = '0;
         ins_rd_d   = '0;
         outst_d    = outst_q - CW'(rsp_ok_c);
         drop_d     = outst_q - CW'(rsp_ok_c);
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
`ifdef RV32_FETCH_ALIGN_CHECK_EN
         misal_d    = (redirect_pc[1:0] != 2'b00);
`endif
      end
   end

   // Control state
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= {RESET_PC[31:2], 2'b00};
         occ_q      <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         ins_wr_q   <= '0;
         ins_rd_q   <= '0;
`ifdef RV32_FETCH_ALIGN_CHECK_EN
         misal_q    <= 1'b0;
`endif
      end else begin
         fetch_pc_q <= fetch_pc_d;
         occ_q      <= occ_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
         ins_wr_q   <= ins_wr_d;
         ins_rd_q   <= ins_rd_d;
`ifdef RV32_FETCH_ALIGN_CHECK_EN
         misal_q    <= misal_d;
`endif
      end
   end

   // FIFO storage, no reset needed (validity tracked by pointers/counters)
   always_ff @(posedge clk) begin
      if (req_fire_c) begin
         tag_mem_q[tag_wr_q] <= fetch_pc_q;
      end
      if (ins_push_c) begin
         ins_mem_q[ins_wr_q] <= fetch_entry_t'({tag_mem_q[tag_rd_q], imem_rsp_data});
      end
   end

   // Memory must never return data that was not requested
   always_ff @(posedge clk) begin
      if (!rst && imem_rsp_valid) begin
         assert (outst_q != '0);
      end
   end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_rv32_fetch_unit
// Self-checking bench for rv32_fetch_unit. A variable-latency in-order memory
// answers the DUT's requests; a queue-based reference model (fetched entries,
// in-flight requests marked stale on redirect) predicts every output cycle.
// Honours RV32_FETCH_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_rv32_fetch_unit;

   localparam int unsigned DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] code_out;
   logic [31:0] pc_out;
   logic        fetch_valid;
`ifdef RV32_FETCH_ALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   always #5 clk = ~clk;

   rv32_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .code_out       (code_out),
      .pc_out         (pc_out),
      .fetch_valid    (fetch_valid)
`ifdef RV32_FETCH_ALIGN_CHECK_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   typedef struct { logic [31:0] pc; logic [31:0] code; } ent_t;
   typedef struct { logic [31:0] pc; bit stale; } tag_t;
   typedef struct { logic [31:0] data; int due; } mrsp_t;

   // Reference model state
   ent_t        m_fifo [$];
   tag_t        m_fly  [$];
   logic [31:0] m_pc;
   bit          m_misal;

   // Memory environment
   mrsp_t       mem_q [$];
   int          lat;

   int          cyc;
   int          n_checks;
   int          n_fail;
   bit          pend_first;
   int          first_wait;
   logic [31:0] first_exp;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive, check against model, advance model and memory
   task automatic step(input logic r, input logic s, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
      logic        rsp_v;
      logic [31:0] rsp_d;
      bit          exp_req;
      bit          exp_fv;
      bit          fire;
      tag_t        t;
      rsp_v = !r && (mem_q.size() > 0) && (mem_q[0].due == cyc);
      rsp_d = rsp_v ? mem_q[0].data : 32'hDEAD_BEEF;
      rst            = r;
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_req_ready = rdy;
      imem_rsp_valid = rsp_v;
      imem_rsp_data  = rsp_d;
      #1;
      exp_req = !r && !rv && !m_misal && ((m_fifo.size() + m_fly.size()) < DEPTH);
      exp_fv  = !r && (m_fifo.size() > 0);
      check("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", imem_req_addr, m_pc);
      check("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
      check("code_out", code_out, exp_fv ? m_fifo[0].code : NOP);
      check("pc_out", pc_out, exp_fv ? m_fifo[0].pc : 32'h0);
`ifdef RV32_FETCH_ALIGN_CHECK_EN
      check("misaligned", 32'(fetch_misaligned), 32'(m_misal));
`endif
      if (pend_first) begin
         if (fetch_valid) begin
            check("first_pc", pc_out, first_exp);
            pend_first = 0;
         end else begin
            first_wait++;
            if (first_wait > 60) begin
               check("first_pc_wait", 32'(fetch_valid), 32'd1);
               pend_first = 0;
            end
         end
      end

      // Memory reacts to what the DUT actually requested
      if (!r && imem_req_valid && rdy)
         mem_q.push_back('{data: mem_word(imem_req_addr), due: cyc + lat});

      fire = exp_req && rdy;
      t = '{pc: 32'h0, stale: 1'b1};
      if (r) begin
         m_fifo.delete();
         m_fly.delete();
         mem_q.delete();
         m_pc    = RST_PC;
         m_misal = 0;
      end else begin
         if (rsp_v) begin
            void'(mem_q.pop_front());
            if (m_fly.size() > 0) t = m_fly.pop_front();
         end
         if (rv) begin
            m_fifo.delete();
            foreach (m_fly[i]) m_fly[i].stale = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
`ifdef RV32_FETCH_ALIGN_CHECK_EN
            m_misal = (rpc[1:0] != 2'b00);
`endif
         end else begin
            if ((m_fifo.size() > 0) && !s) void'(m_fifo.pop_front());
            if (rsp_v && !t.stale) m_fifo.push_back('{pc: t.pc, code: mem_word(t.pc)});
            if (fire) begin
               m_fly.push_back('{pc: m_pc, stale: 1'b0});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic expect_first(input logic [31:0] pc);
      pend_first = 1;
      first_wait = 0;
      first_exp  = pc;
   endtask

   initial begin : main
      bit          rv;
      logic [31:0] rpc;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      lat      = 1;
      pend_first = 0;
      first_wait = 0;
      first_exp  = 32'h0;
      m_pc     = RST_PC;
      m_misal  = 0;
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      @(posedge clk);
      #1;

      // Reset and streaming with a 1-cycle memory
      step(1, 0, 0, 32'h0, 1);
      step(1, 0, 0, 32'h0, 1);
      expect_first(RST_PC);
      repeat (20) step(0, 0, 0, 32'h0, 1);

      // Stall held for 5 cycles, then release
      repeat (5) step(0, 1, 0, 32'h0, 1);
      repeat (10) step(0, 0, 0, 32'h0, 1);

      // Latency 3: redirect while two requests are in flight
      lat = 3;
      step(1, 0, 0, 32'h0, 1);
      repeat (6) step(0, 0, 0, 32'h0, 1);
      for (int i = 0; i < 20; i++) begin
         if (m_fly.size() == 2) break;
         step(0, 0, 0, 32'h0, 1);
      end
      step(0, 0, 1, 32'h100, 1);
      expect_first(32'h100);
      repeat (15) step(0, 0, 0, 32'h0, 1);

      // Redirect coinciding with a response and a pop
      lat = 1;
      step(1, 0, 0, 32'h0, 1);
      for (int i = 0; i < 20; i++) begin
         if ((mem_q.size() > 0) && (mem_q[0].due == cyc) && (m_fifo.size() > 0)) break;
         step(0, 0, 0, 32'h0, 1);
      end
      step(0, 0, 1, 32'h300, 1);
      expect_first(32'h300);
      repeat (8) step(0, 0, 0, 32'h0, 1);

      // Memory not ready for 4 cycles: address held, output drains to NOP
      repeat (4) step(0, 0, 0, 32'h0, 0);
      repeat (8) step(0, 0, 0, 32'h0, 1);

      // Misaligned redirect, then aligned redirect
      step(0, 0, 1, 32'h102, 1);
`ifndef RV32_FETCH_ALIGN_CHECK_EN
      expect_first(32'h100);
`endif
      repeat (10) step(0, 0, 0, 32'h0, 1);
      step(0, 0, 1, 32'h200, 1);
      expect_first(32'h200);
      repeat (10) step(0, 0, 0, 32'h0, 1);

      // Randomized segments, each entered through a mid-run reset
      for (int seg = 0; seg < 6; seg++) begin
         lat = int'($urandom_range(1, 4));
         step(1, 0, 0, 32'h0, 1);
         for (int i = 0; i < 300; i++) begin
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(0, ($urandom_range(0, 9) < 3), rv, rpc, ($urandom_range(0, 9) < 7));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
